// File: rtl/hc138_cs_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// hc138_sched_pkg
//
// Purpose: shared types and constants for the HC138 chip-select scheduler.
//   - sched_state_t : scheduler FSM states (IDLE, ACTIVE, GUARD)
//   - G_EN / G_DIS  : HC138 enable-input patterns (G1 high, G2A/G2B low)
//   - NREQ          : number of requesters sharing the decoder
//   - onehot3       : 3-bit index to 8-bit one-hot helper
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package hc138_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GUARD  = 2'd2
  } sched_state_t;

  // The decoder only drives a Y line low when G1=1 and G2A=G2B=0.
  localparam logic [2:0] G_EN  = 3'b100;
  localparam logic [2:0] G_DIS = 3'b000;

  localparam int NREQ = 8;

  function automatic logic [NREQ-1:0] onehot3(input logic [2:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/hc138_cs_scheduler_rr_arb8.sv
// -----------------------------------------------------------------------------
// rr_arb8
//
// Purpose: purely combinational 8-way round-robin picker. Starting at ptr+1
//   and wrapping modulo 8, it reports the first requester whose bit is set.
//   The search ends at ptr itself, so the last winner is picked again only
//   when it is the sole requester.
//
// Ports:
//   req  in  [7:0]  request vector
//   ptr  in  [2:0]  index of the most recent winner
//   any  out        at least one request bit is set
//   idx  out [2:0]  index of the selected requester (0 when any=0)
// -----------------------------------------------------------------------------
module rr_arb8
  import hc138_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic            any,
  output logic [2:0]      idx
);

  // Walk offsets 1..8; the first hit wins because later hits are masked
  // by 'any'. Offset 8 truncates to 0 and therefore revisits ptr last.
  always_comb begin
    logic [2:0] cand;
    any  = 1'b0;
    idx  = 3'd0;
    cand = 3'd0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = ptr + i[2:0];
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/hc138_cs_scheduler.sv
// -----------------------------------------------------------------------------
// hc138_cs_scheduler
//
// Purpose: round-robin chip-select scheduler sharing one HC138 3-to-8
//   active-low decoder among 8 requesters. Exactly one Y line is low at a
//   time, each grant is capped at HOLD_MAX cycles, and GUARD_CYC dead
//   cycles separate consecutive grants. All outputs are registered.
//
// Parameters:
//   HOLD_MAX   maximum ACTIVE cycles per grant (1 .. 2**CNT_W-1)
//   GUARD_CYC  decoder-disabled cycles between grants (0 = no guard state)
//   CNT_W      width of the shared hold/guard counter
//
// Ports:
//   wb_clk_i  in        clock
//   wb_rst_i  in        synchronous active-high reset
//   en        in        scheduler enable; low blocks new grants only
//   req       in  [7:0] level-sensitive requests
//   dec_a     out [2:0] decoder select A
//   dec_g     out [2:0] decoder enable G (3'b100 on, 3'b000 off)
//   gnt       out [7:0] one-hot grant mirroring the low decoder output
//   busy      out       high in ACTIVE or GUARD
//   timeout   out       one-cycle pulse after a forced release
//
// Build option:
//   HC138_SCHED_PRIO0_EN  when defined, requester 0 wins every arbitration
//                         it takes part in and does not move the rr pointer.
// -----------------------------------------------------------------------------
module hc138_cs_scheduler
  import hc138_sched_pkg::*;
#(
  parameter int unsigned HOLD_MAX  = 16,
  parameter int unsigned GUARD_CYC = 2,
  parameter int unsigned CNT_W     = 5
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [2:0]      dec_a,
  output logic [2:0]      dec_g,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST =
    (GUARD_CYC > 0) ? CNT_W'(GUARD_CYC - 1) : '0;
  localparam logic             HAS_GUARD  = (GUARD_CYC > 0);

  sched_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       ptr, ptr_nxt;
  logic [2:0]       dec_a_nxt;
  logic [2:0]       dec_g_nxt;
  logic [NREQ-1:0]  gnt_nxt;
  logic             busy_nxt;
  logic             timeout_nxt;

  logic             arb_any;
  logic [2:0]       arb_idx;
  logic             win_any;
  logic [2:0]       win_idx;
  logic             win_upd_ptr;
  logic             cur_req;

  rr_arb8 u_arb (
    .req (req),
    .ptr (ptr),
    .any (arb_any),
    .idx (arb_idx)
  );

  // Final winner selection. The optional fixed-priority override for
  // requester 0 sits here so the picker stays a plain round-robin.
  always_comb begin
    win_any     = arb_any;
    win_idx     = arb_idx;
    win_upd_ptr = 1'b1;
`ifdef HC138_SCHED_PRIO0_EN
    if (req[0]) begin
      win_any     = 1'b1;
      win_idx     = 3'd0;
      win_upd_ptr = 1'b0;
    end
`endif
  end

  // The held request is looked up through dec_a rather than ptr because the
  // priority override can grant requester 0 without moving the pointer.
  assign cur_req = req[dec_a];

  // Next-state and next-output logic. Every register has a hold default;
  // timeout defaults low so it can only ever be a single-cycle pulse.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ptr_nxt     = ptr;
    dec_a_nxt   = dec_a;
    dec_g_nxt   = dec_g;
    gnt_nxt     = gnt;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        dec_g_nxt = G_DIS;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        if (en && win_any) begin
          if (win_upd_ptr) begin
            ptr_nxt = win_idx;
          end
          dec_a_nxt = win_idx;
          dec_g_nxt = G_EN;
          gnt_nxt   = onehot3(win_idx);
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ACTIVE;
        end
      end

      ACTIVE: begin
        cnt_nxt = cnt + 1'b1;
        // A request drop takes precedence: if the requester lets go on the
        // same cycle the limit is reached, it is a normal release.
        if (!cur_req || (cnt == HOLD_LAST)) begin
          dec_g_nxt   = G_DIS;
          gnt_nxt     = '0;
          cnt_nxt     = '0;
          timeout_nxt = cur_req;
          if (HAS_GUARD) begin
            state_nxt = GUARD;
            busy_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end
      end

      GUARD: begin
        dec_g_nxt = G_DIS;
        gnt_nxt   = '0;
        busy_nxt  = 1'b1;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == GUARD_LAST) begin
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: begin
        dec_g_nxt = G_DIS;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers. Reset is synchronous and skips the guard:
  // the decoder is disabled on the very next edge. ptr resets to 7 so that
  // requester 0 is searched first.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= 3'd7;
      dec_a   <= 3'd0;
      dec_g   <= G_DIS;
      gnt     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      dec_a   <= dec_a_nxt;
      dec_g   <= dec_g_nxt;
      gnt     <= gnt_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_hc138_cs_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hc138_cs_scheduler
//
// Purpose: directed self-checking bench for hc138_cs_scheduler with the
//   default parameters (HOLD_MAX=16, GUARD_CYC=2, CNT_W=5). Expected values
//   are worked out by hand from the scheduler's timing: a grant appears one
//   edge after the request is sampled in IDLE, lasts at most 16 cycles, then
//   2 guard cycles and one IDLE arbitration cycle follow.
//
// Ports: none.
// -----------------------------------------------------------------------------
module tb_hc138_cs_scheduler;

  logic       wb_clk_i;
  logic       wb_rst_i;
  logic       en;
  logic [7:0] req;
  logic [2:0] dec_a;
  logic [2:0] dec_g;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  int total;
  int bad;

  hc138_cs_scheduler #(
    .HOLD_MAX  (16),
    .GUARD_CYC (2),
    .CNT_W     (5)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .en       (en),
    .req      (req),
    .dec_a    (dec_a),
    .dec_g    (dec_g),
    .gnt      (gnt),
    .busy     (busy),
    .timeout  (timeout)
  );

  // 100 MHz-style free-running clock.
  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  // Drive inputs just after an edge, then advance n edges and settle 1 ns
  // past the last one so outputs are sampled away from the clock edge.
  task automatic applyStimulus(input logic rst, input logic e,
                               input logic [7:0] r, input int n);
    wb_rst_i = rst;
    en       = e;
    req      = r;
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, act, exp, $time);
    end
  endtask

  // Expected grant pattern for the programmed prio0 build option.
  logic [7:0] exp_prio_gnt;
  logic [7:0] exp_oh;

  initial begin
    total = 0;
    bad   = 0;
    wb_rst_i = 1'b1;
    en       = 1'b0;
    req      = 8'h00;

    // Reset state.
    applyStimulus(1'b1, 1'b0, 8'h00, 2);
    checkOutput("rst_dec_a", 32'(dec_a), 32'd0);
    checkOutput("rst_dec_g", 32'(dec_g), 32'b000);
    checkOutput("rst_gnt", 32'(gnt), 32'h00);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);

    // First grant to requester 0, then drop and walk through the guard.
    applyStimulus(1'b0, 1'b1, 8'h01, 1);
    checkOutput("g0_gnt", 32'(gnt), 32'h01);
    checkOutput("g0_dec_a", 32'(dec_a), 32'd0);
    checkOutput("g0_dec_g", 32'(dec_g), 32'b100);
    checkOutput("g0_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h01, 3);
    checkOutput("g0_hold", 32'(gnt), 32'h01);
    applyStimulus(1'b0, 1'b1, 8'h00, 1);
    checkOutput("rel_dec_g", 32'(dec_g), 32'b000);
    checkOutput("rel_gnt", 32'(gnt), 32'h00);
    checkOutput("rel_busy", 32'(busy), 32'd1);
    checkOutput("rel_timeout", 32'(timeout), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1);
    checkOutput("guard2_busy", 32'(busy), 32'd1);
    checkOutput("guard2_dec_g", 32'(dec_g), 32'b000);
    applyStimulus(1'b0, 1'b1, 8'h00, 1);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // All requesters held: full rotation 0..7,0, each forced out at 16.
    applyStimulus(1'b1, 1'b1, 8'h00, 1);
    applyStimulus(1'b0, 1'b1, 8'hFF, 1);
    for (int k = 0; k <= 8; k++) begin
      exp_oh = 8'h01 << (k % 8);
      checkOutput($sformatf("rot%0d_gnt", k), 32'(gnt), 32'(exp_oh));
      checkOutput($sformatf("rot%0d_dec_a", k), 32'(dec_a), 32'(k % 8));
      applyStimulus(1'b0, 1'b1, 8'hFF, 15);
      checkOutput($sformatf("rot%0d_last", k), 32'(gnt), 32'(exp_oh));
      checkOutput($sformatf("rot%0d_noto", k), 32'(timeout), 32'd0);
      if (k < 8) begin
        applyStimulus(1'b0, 1'b1, 8'hFF, 1);
        checkOutput($sformatf("rot%0d_relgnt", k), 32'(gnt), 32'h00);
        checkOutput($sformatf("rot%0d_to", k), 32'(timeout), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1);
        checkOutput($sformatf("rot%0d_topulse", k), 32'(timeout), 32'd0);
        checkOutput($sformatf("rot%0d_guard", k), 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1);
        checkOutput($sformatf("rot%0d_idle", k), 32'(busy), 32'd0);
        checkOutput($sformatf("rot%0d_idleg", k), 32'(dec_g), 32'b000);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1);
      end
    end
    // Drop exactly on the limit cycle: normal release, no timeout.
    applyStimulus(1'b0, 1'b1, 8'h00, 1);
    checkOutput("rot_end_gnt", 32'(gnt), 32'h00);
    checkOutput("rot_end_to", 32'(timeout), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h00, 2);

    // Wrap search: last grant 3, req 0x0A -> 1, then 3.
    applyStimulus(1'b0, 1'b1, 8'h08, 1);
    checkOutput("p3_gnt", 32'(gnt), 32'h08);
    applyStimulus(1'b0, 1'b1, 8'h00, 3);
    applyStimulus(1'b0, 1'b1, 8'h0A, 1);
    checkOutput("wrap_gnt", 32'(gnt), 32'h02);
    checkOutput("wrap_dec_a", 32'(dec_a), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h00, 3);
    applyStimulus(1'b0, 1'b1, 8'h0A, 1);
    checkOutput("next_gnt", 32'(gnt), 32'h08);
    checkOutput("next_dec_a", 32'(dec_a), 32'd3);
    applyStimulus(1'b0, 1'b1, 8'h00, 3);

    // Reset while requester 4 is granted and still requesting.
    applyStimulus(1'b0, 1'b1, 8'h10, 1);
    checkOutput("r4_gnt", 32'(gnt), 32'h10);
    applyStimulus(1'b1, 1'b1, 8'h10, 1);
    checkOutput("mrst_gnt", 32'(gnt), 32'h00);
    checkOutput("mrst_dec_g", 32'(dec_g), 32'b000);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkOutput("mrst_timeout", 32'(timeout), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    checkOutput("mrst_noguard", 32'(busy), 32'd0);
    checkOutput("mrst_noto", 32'(timeout), 32'd0);

    // Enable gating: no new grant while en=0, but a live grant survives it.
    applyStimulus(1'b0, 1'b0, 8'h20, 2);
    checkOutput("en0_gnt", 32'(gnt), 32'h00);
    checkOutput("en0_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h20, 1);
    checkOutput("en1_gnt", 32'(gnt), 32'h20);
    checkOutput("en1_dec_a", 32'(dec_a), 32'd5);
    applyStimulus(1'b0, 1'b0, 8'h20, 3);
    checkOutput("endrop_gnt", 32'(gnt), 32'h20);
    checkOutput("endrop_dec_g", 32'(dec_g), 32'b100);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    checkOutput("endrop_rel", 32'(gnt), 32'h00);
    checkOutput("endrop_to", 32'(timeout), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 2);

    // Requester 0 after it has just been served, competing with 1.
    applyStimulus(1'b1, 1'b1, 8'h00, 1);
    applyStimulus(1'b0, 1'b1, 8'h01, 1);
    checkOutput("p0_gnt", 32'(gnt), 32'h01);
    applyStimulus(1'b0, 1'b1, 8'h00, 3);
`ifdef HC138_SCHED_PRIO0_EN
    exp_prio_gnt = 8'h01;
`else
    exp_prio_gnt = 8'h02;
`endif
    applyStimulus(1'b0, 1'b1, 8'h03, 1);
    checkOutput("prio_gnt", 32'(gnt), 32'(exp_prio_gnt));
    applyStimulus(1'b0, 1'b1, 8'h00, 3);

    // Request drop coinciding with the hold limit: release without timeout.
    applyStimulus(1'b0, 1'b1, 8'h04, 1);
    checkOutput("lim_gnt", 32'(gnt), 32'h04);
    applyStimulus(1'b0, 1'b1, 8'h04, 15);
    checkOutput("lim_hold", 32'(gnt), 32'h04);
    applyStimulus(1'b0, 1'b1, 8'h00, 1);
    checkOutput("lim_rel", 32'(gnt), 32'h00);
    checkOutput("lim_to", 32'(timeout), 32'd0);
    checkOutput("lim_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h00, 2);
    checkOutput("lim_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hc138_cs_scheduler.md
Name: hc138_cs_scheduler

Overview:
- Round-robin chip-select scheduler that shares the 3-to-8 active-low decoder (HC138) among 8 requesters.
- Drives the decoder's select (A) and enable (G) inputs so that exactly one requester's Y line goes low at a time.
- Enforces a maximum hold time per grant and a dead-time (guard) between grants.
- Sits in user_proj_example between io_in request pins and the HC138 instance.

Parameters:
- HOLD_MAX, 16, maximum ACTIVE cycles per grant before forced release; legal range 1..2^CNT_W-1.
- GUARD_CYC, 2, cycles with decoder disabled between grants; 0 = no guard state.
- CNT_W, 5, width of the shared hold/guard counter.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- en  in  1  scheduler enable; low = grant no new requests.
- req  in  8  per-requester request, level-sensitive, synchronous to wb_clk_i.
- dec_a  out  3  decoder select A.
- dec_g  out  3  decoder enable G; 3'b100 = enabled, 3'b000 = disabled.
- gnt  out  8  one-hot grant, mirrors the active (low) decoder output.
- busy  out  1  high in ACTIVE or GUARD.
- timeout  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (sampled at posedge while wb_rst_i=1): state=IDLE, dec_a=0, dec_g=3'b000, gnt=0, busy=0, timeout=0, rr pointer=7 (so requester 0 has first priority), counter=0.
- Reset mid-grant takes effect on the next edge with the same values. No guard is applied.
- All outputs are registered.
- Arbitration:
  - Performed only in IDLE, with en=1 and req!=0.
  - Winner = first set bit of req searching upward from ptr+1 modulo 8.
  - On the same edge: ptr<=winner, dec_a<=winner, dec_g<=3'b100, gnt<=onehot(winner), busy<=1, counter<=0, state<=ACTIVE.
  - Latency: req sampled high at edge N gives the grant visible after edge N.
- ACTIVE:
  - counter increments each cycle.
  - Release when req[ptr]=0 or counter==HOLD_MAX-1.
  - On release: dec_g<=3'b000, gnt<=0, state<=GUARD (or IDLE if GUARD_CYC=0), counter<=0.
  - timeout pulses for the one cycle after release only if req[ptr] was still 1 (forced release).
  - Simultaneous request drop and limit reached: treated as a normal release, no timeout.
  - en falling during ACTIVE does not cut the current grant.
- GUARD:
  - dec_g=3'b000, busy=1.
  - After GUARD_CYC cycles: state<=IDLE, busy<=0.
- IDLE: dec_a holds its last value; dec_g=3'b000. There is no combinational arbitration path to the outputs.
- Invariants:
  - gnt is one-hot or zero.
  - gnt!=0 if and only if dec_g==3'b100.
  - gnt==onehot(dec_a) whenever dec_g==3'b100.
- Back-to-back grants to the same requester are allowed only when it is the sole requester.
- A requester that timed out re-requesting keeps its request bit. The rotation guarantees every other pending requester is served first.

Optional Feature:
- Macro HC138_SCHED_PRIO0_EN.
- Defined: requester 0 is fixed highest priority. If req[0]=1 in IDLE it wins regardless of ptr, and ptr is not updated when 0 wins via override.
- Undefined: pure round-robin as above.

Decomposition:
- Package hc138_sched_pkg:
  - state enum {IDLE, ACTIVE, GUARD}.
  - constants G_EN=3'b100, G_DIS=3'b000, NREQ=8.
- Sub-module rr_arb8: combinational round-robin picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
  - Instantiated once; the macro override lives in the parent.

Test Plan:
- Reset then req=8'h01 -> after one edge dec_a=0, dec_g=3'b100, gnt=8'h01. Drop req -> dec_g=0 for 2 cycles (busy=1), then IDLE.
- req=8'hFF held, HOLD_MAX=16, GUARD_CYC=2 -> grants in order 0,1,...,7,0. Each lasts 16 cycles, each ends with a timeout pulse, and there are 2 guard cycles between grants.
- ptr=3 (last grant 3), req=8'h0A -> grant 1? No: search from 4 wraps to 1, so gnt=8'h02. Next, req=8'h0A again -> gnt=8'h08.
- Assert wb_rst_i during ACTIVE with gnt=8'h10 -> next edge gnt=0, dec_g=0, busy=0, state IDLE, no timeout.
- en=0 with req=8'h20 -> no grant. Raise en -> grant 5 one edge later. Drop en mid-grant -> grant persists until req[5] falls.
- With HC138_SCHED_PRIO0_EN, ptr=0, req=8'h03 -> requester 0 wins again. Without the macro, requester 1 wins.
